// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch unit: FSM state encoding,
// queue entry width helper and the PC alignment mask.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_WAIT = 2'b01,
    FETCH_DROP = 2'b10
  } fetch_state_t;

  localparam int FETCH_DEFAULT_XLEN = 32;
  // One queue entry is {pc, instr}.
  localparam int FETCH_ENTRY_W = 2 * FETCH_DEFAULT_XLEN;

  // Low PC bits that are forced to zero on a redirect.
  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

  function automatic int fetch_entry_w(input int xlen);
    return 2 * xlen;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO for the prefetch queue; flush beats push and pop.
// Head entry is read combinationally so decode sees it the cycle after a push.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign count     = count_reg;
  assign head_data = mem_reg[rd_ptr_reg];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_next = count_reg + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!reset && !flush && do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fetch_unit.sv
// PC generator with a one-outstanding-request icache interface and a prefetch queue.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     icache_access,
  output logic [XLEN-1:0]          icache_address,
  input  logic                     icache_data_ready,
  input  logic [XLEN-1:0]          icache_data_out,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [XLEN-1:0]          dec_pc,
  output logic [XLEN-1:0]          dec_instr,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = fetch_entry_w(XLEN);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  fetch_state_t       state_reg;
  fetch_state_t       state_next;
  logic [XLEN-1:0]    pc_reg;
  logic [XLEN-1:0]    addr_reg;

  logic               accept;
  logic               issue;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W:0]     count_after;

  // A response is kept only while in WAIT and not being redirected.
  assign accept   = (state_reg == FETCH_WAIT) && icache_data_ready && !redirect_valid;
  assign fifo_pop = !fifo_empty && dec_ready && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign fifo_push = accept && (!fifo_full || fifo_pop) && !(fifo_empty && dec_ready);
`else
  assign fifo_push = accept && (!fifo_full || fifo_pop);
`endif

  assign count_after = {1'b0, fifo_count} + {{CNT_W{1'b0}}, fifo_push}
                     - {{CNT_W{1'b0}}, fifo_pop};
  // The next fetch target is loaded on redirect, so never issue in that cycle.
  assign issue = (state_reg == FETCH_IDLE) && !redirect_valid && (count_after < DEPTH_C);

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({addr_reg, icache_data_out}),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH_IDLE: if (issue) state_next = FETCH_WAIT;
      FETCH_WAIT: begin
        if (icache_data_ready)   state_next = FETCH_IDLE;
        else if (redirect_valid) state_next = FETCH_DROP;
      end
      FETCH_DROP: if (icache_data_ready) state_next = FETCH_IDLE;
      default:    state_next = FETCH_IDLE;
    endcase
  end

  always_comb begin
    icache_access  = (state_reg != FETCH_IDLE);
    icache_address = addr_reg;
  end

  // addr_reg holds the request address so a redirect cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg   <= RESET_PC;
      addr_reg <= RESET_PC;
    end else begin
      if (redirect_valid) begin
        pc_reg <= redirect_pc & ~XLEN'(PC_ALIGN_MASK);
      end else if (accept) begin
        pc_reg <= pc_reg + XLEN'(PC_STEP);
      end
      if (issue) addr_reg <= pc_reg;
    end
  end

  always_comb begin
    dec_valid   = !fifo_empty;
    dec_pc      = fifo_head[ENTRY_W-1:XLEN];
    dec_instr   = fifo_head[XLEN-1:0];
    queue_count = fifo_count;
`ifdef FETCH_BYPASS_EN
    if (fifo_empty && accept) begin
      dec_valid = 1'b1;
      dec_pc    = addr_reg;
      dec_instr = icache_data_out;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an icache model answering two cycles after each
// request, plus a scoreboard of expected {pc, instr} pairs checked at decode.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        icache_access;
  logic [31:0] icache_address;
  logic        icache_data_ready;
  logic [31:0] icache_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic [2:0]  queue_count;

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;
  int req_cnt  = 0;
  int wait_cnt = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic        prev_access = 1'b0;
  logic        prev_ready  = 1'b0;
  logic [31:0] prev_addr   = '0;

  fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .icache_access     (icache_access),
    .icache_address    (icache_address),
    .icache_data_ready (icache_data_ready),
    .icache_data_out   (icache_data_out),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .dec_valid         (dec_valid),
    .dec_ready         (dec_ready),
    .dec_pc            (dec_pc),
    .dec_instr         (dec_instr),
    .queue_count       (queue_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, pc ^ 32'hA5A5_0000});
  endtask

  task automatic wait_pops(input int target, input string tag);
    int n = 0;
    while (pop_cnt < target && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_pops"}, pop_cnt, target);
  endtask

  task automatic wait_new_request(input string tag);
    int n = 0;
    while (icache_access !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    while (icache_access !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_req_seen"}, icache_access, 1);
  endtask

  // Instruction cache: responds in the second cycle after the request appears.
  initial begin
    icache_data_ready = 1'b0;
    icache_data_out   = '0;
    forever begin
      @(posedge clk);
      #1;
      icache_data_ready = 1'b0;
      if (icache_access === 1'b1) begin
        if (wait_cnt == 2) begin
          icache_data_ready = 1'b1;
          icache_data_out   = icache_address ^ 32'hA5A5_0000;
          wait_cnt          = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Decode-side monitor and request-address stability check.
  always @(negedge clk) begin
    if (dec_valid === 1'b1 && dec_ready === 1'b1 && redirect_valid !== 1'b1 && reset !== 1'b1) begin
      pop_cnt++;
      $display("DEC pc=0x%08h instr=0x%08h", dec_pc, dec_instr);
      check("dec_expected_avail", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("dec_pc", dec_pc, mon_e[63:32]);
        check("dec_instr", dec_instr, mon_e[31:0]);
      end
    end
    if (prev_access && !prev_ready && icache_access === 1'b1)
      check("addr_stable", icache_address, prev_addr);
    if (icache_access === 1'b1 && !prev_access) req_cnt++;
    prev_access = (icache_access === 1'b1);
    prev_ready  = (icache_data_ready === 1'b1);
    prev_addr   = icache_address;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int req_base;
    int n;
    bit found;

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    repeat (3) tick();
    check("rst_access", icache_access, 0);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_count", queue_count, 0);

    // Streaming fetch with decode always ready; response-to-decode latency is one cycle.
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    base = pop_cnt;
    dec_ready = 1'b1;
    reset = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 50) begin
      @(posedge clk);
      #2;
      if (icache_data_ready === 1'b1) found = 1'b1;
      n++;
    end
    check("p1_first_rsp_seen", 32'(found), 1);
    check("p1_no_bypass", dec_valid, 0);
    check("p1_rsp_addr", icache_address, 32'h0);
    tick();
    check("p1_latency_valid", dec_valid, 1);
    check("p1_latency_pc", dec_pc, 32'h0);
    wait_pops(base + 4, "p1");
    dec_ready = 1'b0;
    check("p1_sb_empty", exp_q.size(), 0);

    // Back-pressure: queue fills to DEPTH and fetching stops.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    req_base = req_cnt;
    repeat (30) tick();
    check("p2_requests", req_cnt - req_base, 4);
    check("p2_count_full", queue_count, 4);
    check("p2_access_idle", icache_access, 0);
    check("p2_dec_valid", dec_valid, 1);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h10);
    base = pop_cnt;
    dec_ready = 1'b1;
    wait_pops(base + 5, "p2");
    dec_ready = 1'b0;
    check("p2_sb_empty", exp_q.size(), 0);

    // Redirect while the request for 0x8 is outstanding.
    reset = 1'b1;
    tick(); tick();
    push_exp(32'h0); push_exp(32'h4);
    base = pop_cnt;
    dec_ready = 1'b1;
    reset = 1'b0;
    n = 0;
    while (!(icache_access === 1'b1 && icache_address === 32'h8) && n < 100) begin
      tick();
      n++;
    end
    check("p3_req8_addr", icache_address, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_valid = 1'b0;
    check("p3_pops_before", pop_cnt - base, 2);
    check("p3_drop_access", icache_access, 1);
    check("p3_drop_addr", icache_address, 32'h8);
    check("p3_flushed_valid", dec_valid, 0);
    check("p3_flushed_count", queue_count, 0);
    push_exp(32'h200); push_exp(32'h204);
    wait_new_request("p3");
    check("p3_target_addr", icache_address, 32'h200);
    wait_pops(base + 4, "p3");
    dec_ready = 1'b0;
    check("p3_sb_empty", exp_q.size(), 0);

    // Redirect coinciding with a response and a pop.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      @(posedge clk);
      #2;
      if (icache_data_ready === 1'b1 && queue_count >= 3'd1) found = 1'b1;
      n++;
    end
    check("p4_setup_seen", 32'(found), 1);
    base = pop_cnt;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    dec_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    dec_ready      = 1'b0;
    check("p4_no_pop", pop_cnt - base, 0);
    check("p4_count", queue_count, 0);
    check("p4_dec_valid", dec_valid, 0);
    check("p4_access", icache_access, 0);
    wait_new_request("p4");
    check("p4_target_addr", icache_address, 32'h300);
    push_exp(32'h300);
    base = pop_cnt;
    dec_ready = 1'b1;
    wait_pops(base + 1, "p4");
    dec_ready = 1'b0;
    check("p4_sb_empty", exp_q.size(), 0);

    // PC wrap past the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    push_exp(32'hFFFF_FFF8); push_exp(32'hFFFF_FFFC); push_exp(32'h0);
    base = pop_cnt;
    dec_ready = 1'b1;
    wait_new_request("p5");
    check("p5_first_addr", icache_address, 32'hFFFF_FFF8);
    wait_pops(base + 3, "p5");
    dec_ready = 1'b0;
    check("p5_sb_empty", exp_q.size(), 0);

    // Reset while a request is outstanding.
    wait_new_request("p6_pre");
    reset = 1'b1;
    tick();
    check("p6_access", icache_access, 0);
    check("p6_dec_valid", dec_valid, 0);
    check("p6_count", queue_count, 0);
    reset = 1'b0;
    push_exp(32'h0);
    base = pop_cnt;
    dec_ready = 1'b1;
    wait_new_request("p6");
    check("p6_reset_pc", icache_address, 32'h0);
    wait_pops(base + 1, "p6");
    dec_ready = 1'b0;
    check("p6_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
